// File: rtl/vote_ballot_box.sv
// Vote ballot box: per-voter sync/debounce/rise detect feeding an IDLE/OPEN/CLOSED round FSM.
// Optional auto-close of a round after TIMEOUT_CYCLES is built only when VOTE_TIMEOUT_EN is defined.
module vote_ballot_box #(
    parameter int N_VOTERS        = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_VOTERS-1:0]           voter_in,
    input  logic                          open_req,
    input  logic                          close_req,
    output logic [N_VOTERS-1:0]           ballots,
    output logic [$clog2(N_VOTERS+1)-1:0] tally,
    output logic                          any_vote,
    output logic                          majority,
    output logic                          round_open,
    output logic                          round_done
);

    localparam int TW = $clog2(N_VOTERS + 1);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HALF     = TW'(N_VOTERS / 2);

    if (N_VOTERS < 2 || N_VOTERS > 16 || DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("vote_ballot_box: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_CLOSED} state_t;

    function automatic logic [TW-1:0] popcount(input logic [N_VOTERS-1:0] v);
        logic [TW-1:0] c;
        c = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            c = c + TW'(v[i]);
        end
        return c;
    endfunction

    logic [N_VOTERS-1:0] sync1_q, sync2_q, level_q, level_prev_q;
    logic [CW-1:0]       cnt_q [N_VOTERS];
    logic [N_VOTERS-1:0] rise_s, acc_s;
    logic [TW-1:0]       acc_cnt_s;
    logic                timeout_s, close_s;

    state_t              state_q;
    logic [N_VOTERS-1:0] ballots_q;
    logic [TW-1:0]       tally_q;
    logic                any_vote_q, majority_q, round_open_q, round_done_q;

    assign rise_s    = level_q & ~level_prev_q;
    assign acc_s     = ballots_q | rise_s;
    assign acc_cnt_s = popcount(acc_s);
    assign close_s   = close_req | timeout_s;

    // Input conditioning: level only follows a value that has been stable for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            for (int i = 0; i < N_VOTERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= voter_in;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            for (int i = 0; i < N_VOTERS; i++) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        level_q[i] <= sync2_q[i];
                        cnt_q[i]   <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

`ifdef VOTE_TIMEOUT_EN
    localparam int TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TOW-1:0] TMO_LAST = TOW'(TIMEOUT_CYCLES - 1);
    logic [TOW-1:0] tmo_q;

    assign timeout_s = (state_q == S_OPEN) && (tmo_q == TMO_LAST);

    // Round-age counter: zero outside OPEN, including the cycle after the round closes.
    always_ff @(posedge clk) begin
        if (rst || state_q != S_OPEN || close_s) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TOW'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Round FSM with registered ballot, summary and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ballots_q    <= '0;
            tally_q      <= '0;
            any_vote_q   <= 1'b0;
            majority_q   <= 1'b0;
            round_open_q <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            round_done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_CLOSED: begin
                    if (open_req) begin
                        state_q      <= S_OPEN;
                        round_open_q <= 1'b1;
                        ballots_q    <= '0;
                        tally_q      <= '0;
                        any_vote_q   <= 1'b0;
                        majority_q   <= 1'b0;
                    end
                end
                S_OPEN: begin
                    ballots_q  <= acc_s;
                    tally_q    <= acc_cnt_s;
                    any_vote_q <= |acc_s;
                    majority_q <= (acc_cnt_s > HALF);
                    if (close_s) begin
                        state_q      <= S_CLOSED;
                        round_open_q <= 1'b0;
                        round_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    round_open_q <= 1'b0;
                end
            endcase
        end
    end

    assign ballots    = ballots_q;
    assign tally      = tally_q;
    assign any_vote   = any_vote_q;
    assign majority   = majority_q;
    assign round_open = round_open_q;
    assign round_done = round_done_q;

endmodule

// File: tb/tb_vote_ballot_box.sv
// Directed self-checking bench for vote_ballot_box (N_VOTERS=8, DEBOUNCE_CYCLES=4).
module tb_vote_ballot_box;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] voter_in = 8'h00;
    logic       open_req = 1'b0;
    logic       close_req = 1'b0;
    logic [7:0] ballots;
    logic [3:0] tally;
    logic       any_vote, majority, round_open, round_done;

    int n_total = 0;
    int n_bad   = 0;

    vote_ballot_box #(
        .N_VOTERS(8), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .rst(rst), .voter_in(voter_in), .open_req(open_req), .close_req(close_req),
        .ballots(ballots), .tally(tally), .any_vote(any_vote), .majority(majority),
        .round_open(round_open), .round_done(round_done)
    );

`ifdef VOTE_TIMEOUT_EN
    logic       t_open = 1'b0;
    logic       t_close = 1'b0;
    logic [7:0] t_ballots;
    logic [3:0] t_tally;
    logic       t_any, t_maj, t_ro, t_done;

    vote_ballot_box #(
        .N_VOTERS(8), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)
    ) dut_t (
        .clk(clk), .rst(rst), .voter_in(8'h00), .open_req(t_open), .close_req(t_close),
        .ballots(t_ballots), .tally(t_tally), .any_vote(t_any), .majority(t_maj),
        .round_open(t_ro), .round_done(t_done)
    );
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges, leaving time 1 unit after the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_open();
        open_req = 1'b1;
        step(1);
        open_req = 1'b0;
    endtask

    task automatic pulse_close();
        close_req = 1'b1;
        step(1);
        close_req = 1'b0;
    endtask

    initial begin
        int         vlist [5];
        logic [7:0] exp_mask;
        int         n;
        vlist = '{0, 2, 4, 6, 7};

        // Reset, then idle with every button held
        voter_in = 8'hFF;
        rst = 1'b1;
        step(3);
        chk("rst_ballots", ballots, 8'h00);
        chk("rst_tally", tally, 4'd0);
        chk("rst_any", any_vote, 1'b0);
        chk("rst_maj", majority, 1'b0);
        chk("rst_open", round_open, 1'b0);
        chk("rst_done", round_done, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("idle_ballots", ballots, 8'h00);
            chk("idle_tally", tally, 4'd0);
            chk("idle_open", round_open, 1'b0);
        end
        voter_in = 8'h00;
        step(12);

        // Basic round: voters 0,2,4,6,7
        pulse_open();
        chk("open_ro", round_open, 1'b1);
        chk("open_ballots", ballots, 8'h00);
        exp_mask = 8'h00;
        for (int i = 0; i < 5; i++) begin
            voter_in[vlist[i]] = 1'b1;
            step(20);
            voter_in[vlist[i]] = 1'b0;
            step(10);
            exp_mask[vlist[i]] = 1'b1;
            chk("basic_ballots", ballots, exp_mask);
            chk("basic_tally", tally, i + 1);
            chk("basic_maj", majority, (i + 1) > 4);
        end
        pulse_close();
        chk("close_done", round_done, 1'b1);
        chk("close_ro", round_open, 1'b0);
        chk("close_ballots", ballots, 8'hD5);
        chk("close_tally", tally, 4'd5);
        chk("close_maj", majority, 1'b1);
        chk("close_any", any_vote, 1'b1);
        step(1);
        chk("done_one_cycle", round_done, 1'b0);
        voter_in[1] = 1'b1;
        step(15);
        voter_in[1] = 1'b0;
        step(10);
        chk("closed_frozen", ballots, 8'hD5);
        chk("closed_tally", tally, 4'd5);

        // Reopen from CLOSED, glitch rejection and press latency
        pulse_open();
        chk("reopen_ballots", ballots, 8'h00);
        chk("reopen_tally", tally, 4'd0);
        chk("reopen_any", any_vote, 1'b0);
        chk("reopen_no_done", round_done, 1'b0);
        voter_in[1] = 1'b1;
        step(3);
        voter_in[1] = 1'b0;
        step(15);
        chk("glitch_ignored", ballots, 8'h00);
        voter_in[1] = 1'b1;
        step(6);
        chk("lat_k5", ballots[1], 1'b0);
        step(1);
        chk("lat_k6", ballots[1], 1'b1);
        step(10);
        voter_in[1] = 1'b0;
        step(10);

        // Sticky, simultaneous, held-before-open
        pulse_close();
        voter_in[0] = 1'b1;
        step(12);
        pulse_open();
        voter_in[3] = 1'b1;
        voter_in[5] = 1'b1;
        step(12);
        chk("simul_ballots", ballots, 8'h28);
        chk("simul_tally", tally, 4'd2);
        for (int i = 0; i < 4; i++) begin
            voter_in[3] = 1'b0;
            step(10);
            voter_in[3] = 1'b1;
            step(10);
        end
        chk("sticky_ballots", ballots, 8'h28);
        chk("sticky_tally", tally, 4'd2);
        voter_in = 8'h00;
        step(12);

        // Simultaneous open+close in OPEN and in CLOSED
        open_req = 1'b1;
        close_req = 1'b1;
        step(1);
        chk("both_open_ro", round_open, 1'b0);
        chk("both_open_done", round_done, 1'b1);
        step(1);
        chk("both_closed_ro", round_open, 1'b1);
        chk("both_closed_done", round_done, 1'b0);
        chk("both_closed_tally", tally, 4'd0);
        open_req = 1'b0;
        close_req = 1'b0;
        voter_in = 8'h0F;
        step(12);
        chk("four_tally", tally, 4'd4);
        chk("four_maj", majority, 1'b0);
        pulse_open();
        chk("open_in_open", ballots, 8'h0F);
        chk("open_in_open_ro", round_open, 1'b1);

        // Reset mid-round
        voter_in = 8'h00;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_ballots", ballots, 8'h00);
        chk("midrst_tally", tally, 4'd0);
        chk("midrst_any", any_vote, 1'b0);
        chk("midrst_ro", round_open, 1'b0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (round_done) n++;
        end
        chk("midrst_no_done", n, 0);
        pulse_close();
        chk("close_in_idle_ro", round_open, 1'b0);
        chk("close_in_idle_done", round_done, 1'b0);

        // Rise coinciding with the closing edge still counts
        pulse_open();
        voter_in[6] = 1'b1;
        step(6);
        pulse_close();
        chk("edge_close_ballots", ballots, 8'h40);
        chk("edge_close_tally", tally, 4'd1);
        chk("edge_close_done", round_done, 1'b1);
        voter_in = 8'h00;
        step(10);

`ifdef VOTE_TIMEOUT_EN
        t_open = 1'b1;
        step(1);
        t_open = 1'b0;
        n = 0;
        while (n < 200 && !t_done) begin
            step(1);
            n++;
        end
        chk("tmo_len", n, 100);
        step(5);
        t_open = 1'b1;
        step(1);
        t_open = 1'b0;
        step(39);
        t_close = 1'b1;
        step(1);
        t_close = 1'b0;
        chk("tmo_early_done", t_done, 1'b1);
        n = 0;
        for (int i = 0; i < 150; i++) begin
            step(1);
            if (t_done) n++;
        end
        chk("tmo_no_late_done", n, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
